// File: rtl/wb_register_file.sv
// Writeback register file: 32 GPRs (r0 reads as zero) plus HI/LO, two
// bypassable combinational read ports and an array-only debug read port.
module wb_register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rf_enable,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hi_enable,
  input  logic [DATA_W-1:0] hi_data,
  input  logic              lo_enable,
  input  logic [DATA_W-1:0] lo_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam bit          L_BYP = (BYPASS != 0);

  logic [DATA_W-1:0] r_gpr [NREG];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic              w_gpr_we;
  logic [DATA_W-1:0] w_ra_arr;
  logic [DATA_W-1:0] w_rb_arr;
  logic [DATA_W-1:0] w_dbg_arr;
  logic              w_ra_byp;
  logic              w_rb_byp;
  logic              w_hi_byp;
  logic              w_lo_byp;

  // Writes to r0 are dropped here so the entry never leaves its reset value.
  assign w_gpr_we = rf_enable && (wr_addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_gpr_we) begin
      r_gpr[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (hi_enable) r_hi <= hi_data;
      if (lo_enable) r_lo <= lo_data;
    end
  end

  // Stored-contents lookups; address 0 is forced to zero explicitly.
  always_comb begin
    w_ra_arr  = '0;
    w_rb_arr  = '0;
    w_dbg_arr = '0;
    if (ra_addr  != '0) w_ra_arr  = r_gpr[ra_addr];
    if (rb_addr  != '0) w_rb_arr  = r_gpr[rb_addr];
    if (dbg_addr != '0) w_dbg_arr = r_gpr[dbg_addr];
  end

  always_comb begin
    w_ra_byp = L_BYP && w_gpr_we && (wr_addr == ra_addr);
    w_rb_byp = L_BYP && w_gpr_we && (wr_addr == rb_addr);
    w_hi_byp = L_BYP && hi_enable;
    w_lo_byp = L_BYP && lo_enable;
  end

  // Reset gates every output to zero and suppresses bypass.
  always_comb begin
    ra_data  = '0;
    rb_data  = '0;
    hi_out   = '0;
    lo_out   = '0;
    dbg_data = '0;
    if (!reset) begin
      ra_data  = w_ra_byp ? wr_data : w_ra_arr;
      rb_data  = w_rb_byp ? wr_data : w_rb_arr;
      hi_out   = w_hi_byp ? hi_data : r_hi;
      lo_out   = w_lo_byp ? lo_data : r_lo;
      dbg_data = w_dbg_arr;
    end
  end

endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: a BYPASS=1 and a BYPASS=0 instance share stimulus
// and are checked against an array model of the architectural state.
module tb_wb_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          rf_enable, hi_enable, lo_enable;
  logic [AW-1:0] wr_addr, ra_addr, rb_addr, dbg_addr;
  logic [DW-1:0] wr_data, hi_data, lo_data;

  logic [DW-1:0] ra1, rb1, hi1, lo1, dbg1;
  logic [DW-1:0] ra0, rb0, hi0, lo0, dbg0;

  logic [DW-1:0] mdl [32];
  logic [DW-1:0] mdl_hi, mdl_lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_register_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .rf_enable(rf_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .hi_enable(hi_enable), .hi_data(hi_data), .lo_enable(lo_enable), .lo_data(lo_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra1), .rb_data(rb1),
    .hi_out(hi1), .lo_out(lo1), .dbg_addr(dbg_addr), .dbg_data(dbg1));

  wb_register_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset(reset), .rf_enable(rf_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .hi_enable(hi_enable), .hi_data(hi_data), .lo_enable(lo_enable), .lo_data(lo_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra0), .rb_data(rb0),
    .hi_out(hi0), .lo_out(lo0), .dbg_addr(dbg_addr), .dbg_data(dbg0));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural view of a GPR read, as seen by the ID stage this cycle.
  function automatic logic [DW-1:0] exp_gpr(input logic [AW-1:0] a, input bit byp);
    if (reset || a == 0) return '0;
    if (byp && rf_enable && wr_addr == a) return wr_data;
    return mdl[a];
  endfunction

  function automatic logic [DW-1:0] exp_hl(input bit en, input logic [DW-1:0] d,
                                           input logic [DW-1:0] stored, input bit byp);
    if (reset) return '0;
    return (byp && en) ? d : stored;
  endfunction

  task automatic check_all();
    chk("ra_byp",   ra1,  exp_gpr(ra_addr, 1'b1));
    chk("rb_byp",   rb1,  exp_gpr(rb_addr, 1'b1));
    chk("hi_byp",   hi1,  exp_hl(hi_enable, hi_data, mdl_hi, 1'b1));
    chk("lo_byp",   lo1,  exp_hl(lo_enable, lo_data, mdl_lo, 1'b1));
    chk("dbg_byp",  dbg1, exp_gpr(dbg_addr, 1'b0));
    chk("ra_nobyp", ra0,  exp_gpr(ra_addr, 1'b0));
    chk("rb_nobyp", rb0,  exp_gpr(rb_addr, 1'b0));
    chk("hi_nobyp", hi0,  exp_hl(hi_enable, hi_data, mdl_hi, 1'b0));
    chk("lo_nobyp", lo0,  exp_hl(lo_enable, lo_data, mdl_lo, 1'b0));
    chk("dbg_nobyp", dbg0, exp_gpr(dbg_addr, 1'b0));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl_hi = '0;
    mdl_lo = '0;
  endtask

  task automatic commit();
    if (reset) begin
      clear_model();
    end else begin
      if (rf_enable && wr_addr != 0) mdl[wr_addr] = wr_data;
      if (hi_enable) mdl_hi = hi_data;
      if (lo_enable) mdl_lo = lo_data;
    end
  endtask

  // Inputs are already driven; check before the edge, then update the model.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle();
    rf_enable = 1'b0;
    hi_enable = 1'b0;
    lo_enable = 1'b0;
  endtask

  task automatic sweep_dbg();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk("dbg_sweep_byp",   dbg1, exp_gpr(dbg_addr, 1'b0));
      chk("dbg_sweep_nobyp", dbg0, exp_gpr(dbg_addr, 1'b0));
    end
  endtask

  task automatic write_gpr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    rf_enable = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    cycle();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; hi_data = '0; lo_data = '0;
    ra_addr = '0; rb_addr = '0; dbg_addr = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    #1;

    // Reset state everywhere, then a single write visible after the edge.
    sweep_dbg();
    write_gpr(5'd5, 32'hDEAD_BEEF);
    dbg_addr = 5'd5;
    #1;
    chk("r5_after_edge", dbg1, 32'hDEAD_BEEF);
    sweep_dbg();

    // Writes to r0 never land, and r0 never bypasses.
    rf_enable = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    ra_addr = 5'd0; rb_addr = 5'd0; dbg_addr = 5'd0;
    #1;
    chk("r0_bypass_ra", ra1, 32'h0);
    cycle();
    idle();
    #1;
    chk("r0_after_ra", ra1, 32'h0);
    chk("r0_after_dbg", dbg1, 32'h0);

    // Same-cycle write to r7 on both read ports; old value first so the
    // non-bypassed instance has something distinct to hold.
    write_gpr(5'd7, 32'hAAAA_5555);
    rf_enable = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
    ra_addr = 5'd7; rb_addr = 5'd7; dbg_addr = 5'd7;
    #1;
    chk("r7_same_ra_byp", ra1, 32'h1234_5678);
    chk("r7_same_rb_byp", rb1, 32'h1234_5678);
    chk("r7_same_dbg_old", dbg1, 32'hAAAA_5555);
    chk("r7_same_ra_nobyp", ra0, 32'hAAAA_5555);
    cycle();
    idle();
    #1;
    chk("r7_next_dbg", dbg1, 32'h1234_5678);
    chk("r7_next_ra_nobyp", ra0, 32'h1234_5678);

    // HI, LO and a GPR all written in one cycle.
    rf_enable = 1'b1; wr_addr = 5'd3; wr_data = 32'h3;
    hi_enable = 1'b1; hi_data = 32'h1;
    lo_enable = 1'b1; lo_data = 32'h2;
    cycle();
    idle();
    dbg_addr = 5'd3;
    #1;
    chk("hi_after_mult", hi0, 32'h1);
    chk("lo_after_mult", lo0, 32'h2);
    chk("r3_after_mult", dbg0, 32'h3);

    // Load r1..r31 with their index, then a 1 ns reset pulse between edges.
    for (int i = 1; i < 32; i++) write_gpr(AW'(i), DW'(i));
    sweep_dbg();
    ra_addr = 5'd12; rb_addr = 5'd31; dbg_addr = 5'd9;
    rf_enable = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE_F00D;
    hi_enable = 1'b1; hi_data = 32'h55;
    reset = 1'b1;
    #1;
    chk("pulse_ra", ra1, 32'h0);
    chk("pulse_rb", rb1, 32'h0);
    chk("pulse_hi", hi1, 32'h0);
    chk("pulse_dbg", dbg0, 32'h0);
    idle();
    reset = 1'b0;
    clear_model();
    #1;
    sweep_dbg();

    // Write presented while reset is held across an edge is discarded.
    write_gpr(5'd9, 32'h0000_0099);
    reset = 1'b1;
    rf_enable = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE_F00D;
    hi_enable = 1'b1; hi_data = 32'h77;
    cycle();
    reset = 1'b0;
    idle();
    dbg_addr = 5'd9;
    #1;
    chk("held_write_dropped", dbg1, 32'h0);
    chk("held_hi_dropped", hi1, 32'h0);

    // Randomized traffic with addresses biased toward collisions.
    for (int n = 0; n < 300; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      rf_enable = $urandom_range(0, 3) != 0;
      wr_addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
      wr_data   = DW'($urandom);
      hi_enable = $urandom_range(0, 2) == 0;
      lo_enable = $urandom_range(0, 2) == 0;
      hi_data   = DW'($urandom);
      lo_data   = DW'($urandom);
      ra_addr   = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
      rb_addr   = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
      dbg_addr  = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
      cycle();
    end
    reset = 1'b0;
    idle();
    sweep_dbg();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
